// File: rtl/gram_pkg.sv
// Shared widths, burst FSM state encodings and the bank rotation helper
// for the SDRAM frame-buffer scheduler.
package gram_pkg;

    localparam int BANK_W = 2;
    localparam int ADDR_W = 22;
    localparam int LVL_W  = 10;

    localparam logic [1:0] BURST_IDLE = 2'd0;
    localparam logic [1:0] BURST_REQ  = 2'd1;
    localparam logic [1:0] BURST_WAIT = 2'd2;

    // Writer's next bank after publishing `latest`; with three banks it skips the reader's bank.
    function automatic logic [BANK_W-1:0] next_bank(
        input logic              triple,
        input logic [BANK_W-1:0] latest,
        input logic [BANK_W-1:0] r_bank
    );
        logic [BANK_W-1:0] plus1;
        logic [BANK_W-1:0] plus2;
        if (!triple) begin
            return BANK_W'(!latest[0]);
        end
        plus1 = (latest == BANK_W'(2)) ? '0 : latest + BANK_W'(1);
        plus2 = (latest == BANK_W'(0)) ? BANK_W'(2) : latest - BANK_W'(1);
        return (plus1 == r_bank) ? plus2 : plus1;
    endfunction

endpackage

// File: rtl/gram_burst_fsm.sv
// One-direction burst handshake: IDLE -> REQ (single-cycle request) -> WAIT,
// leaving WAIT on the falling edge of the core's busy flag.
module gram_burst_fsm
    import gram_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic busy,
    output logic req,
    output logic done,
    output logic idle
);

    logic [1:0] state;
    logic [1:0] state_nx;
    logic       busy_q;

    assign req  = (state == BURST_REQ);
    assign idle = (state == BURST_IDLE);
    assign done = (state == BURST_WAIT) && busy_q && !busy;

    always_comb begin
        state_nx = state;
        case (state)
            BURST_IDLE: if (start) state_nx = BURST_REQ;
            BURST_REQ:  state_nx = BURST_WAIT;
            BURST_WAIT: if (done) state_nx = BURST_IDLE;
            default:    state_nx = BURST_IDLE;
        endcase
    end

    // busy_q is forced low across REQ so a stale busy cannot fake a completion edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= BURST_IDLE;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nx;
            busy_q <= (state == BURST_REQ) ? 1'b0 : busy;
        end
    end

endmodule

// File: rtl/gram_frame_sched.sv
// SDRAM frame-buffer burst scheduler: write/read burst requests from FIFO levels,
// double/triple bank rotation, frame-sync realignment and dropped-frame counting.
module gram_frame_sched
    import gram_pkg::*;
#(
    parameter int FIFO_DEPTH   = 512,
    parameter int BURST_LEN    = 256,
    parameter int FRAME_BURSTS = 1200,
    parameter int TRIPLE       = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     init_done,
    input  logic [LVL_W-1:0]         wr_level,
    input  logic [LVL_W-1:0]         rd_level,
    input  logic                     wr_frame_sync,
    input  logic                     rd_frame_sync,
    input  logic                     wr_busy,
    input  logic                     rd_busy,
    output logic                     wr_req,
    output logic [BANK_W+ADDR_W-1:0] wr_addr,
    output logic                     rd_req,
    output logic [BANK_W+ADDR_W-1:0] rd_addr,
    output logic                     frame_valid,
    output logic                     frame_done,
    output logic [7:0]               drop_cnt
);

    localparam int                IDX_W      = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
    localparam int                COL_SH     = $clog2(BURST_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(FRAME_BURSTS - 1);
    localparam logic [BANK_W-1:0] RESET_BANK = (TRIPLE != 0) ? BANK_W'(2) : BANK_W'(1);
    localparam logic [LVL_W:0]    WR_THRESH  = (LVL_W + 1)'(BURST_LEN);
    localparam logic [LVL_W:0]    RD_THRESH  = (LVL_W + 1)'(FIFO_DEPTH - BURST_LEN);

    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [BANK_W-1:0] w_bank;
    logic [BANK_W-1:0] r_bank;
    logic [BANK_W-1:0] latest;
    logic [BANK_W-1:0] latest_nx;
    logic [BANK_W-1:0] r_bank_nx;
    logic [BANK_W-1:0] w_bank_nx;
    logic              aligned;
    logic              wr_abort_pend;
    logic              rd_sync_pend;
    logic              wr_start, rd_start;
    logic              wr_done, rd_done;
    logic              wr_idle, rd_idle;
    logic              wr_abort, wr_complete, rd_apply;

    assign wr_start = init_done && aligned && !wr_busy && ({1'b0, wr_level} >= WR_THRESH);
    assign rd_start = init_done && frame_valid && !rd_busy && ({1'b0, rd_level} <= RD_THRESH);

    gram_burst_fsm u_wr_fsm (
        .clk   (clk),
        .rst_n (rst_n),
        .start (wr_start),
        .busy  (wr_busy),
        .req   (wr_req),
        .done  (wr_done),
        .idle  (wr_idle)
    );

    gram_burst_fsm u_rd_fsm (
        .clk   (clk),
        .rst_n (rst_n),
        .start (rd_start),
        .busy  (rd_busy),
        .req   (rd_req),
        .done  (rd_done),
        .idle  (rd_idle)
    );

    // A camera sync while a burst is in flight is deferred to that burst's completion.
    assign wr_abort    = wr_done ? (wr_abort_pend || wr_frame_sync)
                                 : (wr_idle && wr_frame_sync && (wr_idx != '0));
    assign wr_complete = wr_done && !wr_abort && (wr_idx == LAST_IDX);
    assign rd_apply    = rd_idle && (rd_frame_sync || rd_sync_pend);

    // Reader realignment sees a same-cycle publish, and the writer's pick sees that reader bank.
    assign latest_nx = wr_complete ? w_bank : latest;
    assign r_bank_nx = rd_apply ? latest_nx : r_bank;
    assign w_bank_nx = next_bank(TRIPLE != 0, latest_nx, r_bank_nx);

    assign wr_addr = {w_bank, ADDR_W'(wr_idx) << COL_SH};
    assign rd_addr = {r_bank, ADDR_W'(rd_idx) << COL_SH};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx        <= '0;
            rd_idx        <= '0;
            w_bank        <= '0;
            r_bank        <= RESET_BANK;
            latest        <= RESET_BANK;
            aligned       <= 1'b0;
            wr_abort_pend <= 1'b0;
            rd_sync_pend  <= 1'b0;
            frame_valid   <= 1'b0;
            frame_done    <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            frame_done <= wr_complete;
            if (wr_frame_sync) aligned <= 1'b1;

            if (wr_abort) begin
                wr_idx <= '0;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end else if (wr_done) begin
                wr_idx <= wr_complete ? '0 : wr_idx + 1'b1;
            end
            wr_abort_pend <= !wr_abort && (wr_abort_pend || (wr_frame_sync && !wr_idle));

            if (wr_complete) begin
                latest      <= w_bank;
                frame_valid <= 1'b1;
                w_bank      <= w_bank_nx;
            end

            if (rd_apply) begin
                rd_idx <= '0;
                r_bank <= r_bank_nx;
            end else if (rd_done) begin
                rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
            end
            rd_sync_pend <= !rd_apply && (rd_sync_pend || rd_frame_sync);
        end
    end

endmodule
